// File: rtl/parity_frame_serializer_pkg.sv
// Shared state encoding, output bundle and sizing helpers for the parity frame serializer.
package parity_frame_serializer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2,
    ST_GAP    = 2'd3
  } pfs_state_e;

  typedef struct packed {
    logic seq;
    logic vld;
    logic start;
    logic last;
  } pfs_out_t;

  localparam int DEF_WIDTH      = 8;
  localparam int DEF_ADD_PARITY = 1;
  localparam int DEF_IDLE_GAP   = 0;
  localparam int GAP_CNT_W      = 8;

  // Cycles occupied by one frame on the serial side.
  function automatic int frame_len(input int width, input int add_parity);
    return width + ((add_parity != 0) ? 1 : 0);
  endfunction

  function automatic int cnt_width(input int width);
    return (width < 1) ? 1 : $clog2(width + 1);
  endfunction

endpackage

// File: rtl/parity_frame_serializer_if.sv
// Word-side handshake plus serial-side frame signals of the parity frame serializer.
interface parity_frame_serializer_if
  import parity_frame_serializer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic [WIDTH-1:0] wordIn;
  logic             wordValid;
  logic             wordReady;
  logic             seqOut;
  logic             seqValid;
  logic             frameStart;
  logic             frameLast;

  modport master (
    output wordIn,
    output wordValid,
    input  wordReady,
    input  seqOut,
    input  seqValid,
    input  frameStart,
    input  frameLast
  );

  modport slave (
    input  wordIn,
    input  wordValid,
    output wordReady,
    output seqOut,
    output seqValid,
    output frameStart,
    output frameLast
  );
endinterface

// File: rtl/parity_frame_serializer.sv
// Serializes parallel words LSB-first, optionally appending an even-parity bit,
// with an optional idle gap between frames.
module parity_frame_serializer
  import parity_frame_serializer_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int ADD_PARITY = DEF_ADD_PARITY,
  parameter int IDLE_GAP   = DEF_IDLE_GAP
) (
  input  logic clk,
  input  logic rst,
  parity_frame_serializer_if.slave bus
);

  localparam int FRAME_LEN = frame_len(WIDTH, ADD_PARITY);
  localparam int CNT_W     = cnt_width(WIDTH);

  localparam logic [CNT_W-1:0]     DATA_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0]     FINAL_IDX = CNT_W'(FRAME_LEN - 1);
  localparam logic [GAP_CNT_W-1:0] GAP_LOAD  = GAP_CNT_W'((IDLE_GAP >= 2) ? IDLE_GAP - 2 : 0);

  localparam logic [1:0] S_IDLE   = ST_IDLE;
  localparam logic [1:0] S_SHIFT  = ST_SHIFT;
  localparam logic [1:0] S_PARITY = ST_PARITY;
  localparam logic [1:0] S_GAP    = ST_GAP;

  logic [1:0]           r_state, w_state_nxt;
  logic [WIDTH-1:0]     r_shreg, w_shreg_nxt;
  logic [CNT_W-1:0]     r_cnt, w_cnt_nxt, w_cnt_inc;
  logic                 r_par, w_par_nxt;
  logic [GAP_CNT_W-1:0] r_gap, w_gap_nxt;
  pfs_out_t             r_out, w_out_nxt;
  logic                 w_final;
  logic                 w_ready;
  logic                 w_xfer;

  // r_cnt is the frame position of the bit currently on the output register,
  // so the parity cycle sits at position WIDTH.
  assign w_cnt_inc = r_cnt + CNT_W'(1);
  assign w_final   = ((r_state == S_SHIFT) || (r_state == S_PARITY)) && (r_cnt == FINAL_IDX);
  assign w_ready   = !rst && ((r_state == S_IDLE) || (w_final && (IDLE_GAP == 0)));
  assign w_xfer    = bus.wordValid && w_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_shreg_nxt = r_shreg;
    w_cnt_nxt   = r_cnt;
    w_par_nxt   = r_par;
    w_gap_nxt   = r_gap;
    w_out_nxt   = '0;
    if (w_xfer) begin
      w_state_nxt     = S_SHIFT;
      w_shreg_nxt     = bus.wordIn >> 1;
      w_cnt_nxt       = '0;
      w_par_nxt       = bus.wordIn[0];
      w_out_nxt.seq   = bus.wordIn[0];
      w_out_nxt.vld   = 1'b1;
      w_out_nxt.start = 1'b1;
      w_out_nxt.last  = (FINAL_IDX == '0);
    end else if (w_final) begin
      // The Idle cycle that accepts the next word counts as the last gap cycle.
      w_state_nxt = (IDLE_GAP >= 2) ? S_GAP : S_IDLE;
      w_gap_nxt   = GAP_LOAD;
    end else begin
      case (r_state)
        S_SHIFT: begin
          w_cnt_nxt      = w_cnt_inc;
          w_out_nxt.vld  = 1'b1;
          w_out_nxt.last = (w_cnt_inc == FINAL_IDX);
          if (r_cnt == DATA_LAST) begin
            w_state_nxt   = S_PARITY;
            w_out_nxt.seq = r_par;
          end else begin
            w_out_nxt.seq = r_shreg[0];
            w_shreg_nxt   = r_shreg >> 1;
            w_par_nxt     = r_par ^ r_shreg[0];
          end
        end
        S_GAP: begin
          if (r_gap == '0) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_gap_nxt = r_gap - GAP_CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_shreg <= '0;
      r_cnt   <= '0;
      r_par   <= 1'b0;
      r_gap   <= '0;
      r_out   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_shreg <= w_shreg_nxt;
      r_cnt   <= w_cnt_nxt;
      r_par   <= w_par_nxt;
      r_gap   <= w_gap_nxt;
      r_out   <= w_out_nxt;
    end
  end

  assign bus.wordReady  = w_ready;
  assign bus.seqOut     = r_out.seq;
  assign bus.seqValid   = r_out.vld;
  assign bus.frameStart = r_out.start;
  assign bus.frameLast  = r_out.last;

endmodule

// File: tb/tb_parity_frame_serializer.sv
// Bench for parity_frame_serializer: three configurations share one clock and reset.
module tb_parity_frame_serializer;
  import parity_frame_serializer_pkg::*;

  typedef struct { logic b; logic s; logic l; } exp_t;
  typedef struct { logic [7:0] word; logic [0:7] seq; logic par; } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  parity_frame_serializer_if #(.WIDTH(8)) a_if ();
  parity_frame_serializer_if #(.WIDTH(8)) b_if ();
  parity_frame_serializer_if #(.WIDTH(1)) c_if ();

  parity_frame_serializer #(.WIDTH(8), .ADD_PARITY(1), .IDLE_GAP(0)) dut_a (.clk(clk), .rst(rst), .bus(a_if));
  parity_frame_serializer #(.WIDTH(8), .ADD_PARITY(1), .IDLE_GAP(2)) dut_b (.clk(clk), .rst(rst), .bus(b_if));
  parity_frame_serializer #(.WIDTH(1), .ADD_PARITY(0), .IDLE_GAP(0)) dut_c (.clk(clk), .rst(rst), .bus(c_if));

  int   total = 0;
  int   bad = 0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];
  int   run[3];
  int   run_max[3];
  int   gapz[3];
  int   gap_meas[3];
  bit   seen_last[3];
  bit   ones[3];
  bit   xf[3];
  int   gap_cfg[3] = '{0, 2, 0};
  bit   ap_cfg[3]  = '{1'b1, 1'b1, 1'b0};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_item(input int id, input exp_t e);
    case (id)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  // Reference model: LSB-first bits, then the XOR of all data bits.
  task automatic push_word(input int id, input int width, input bit ap, input logic [7:0] word);
    exp_t e;
    logic p;
    p = 1'b0;
    for (int k = 0; k < width; k++) begin
      e.b = word[k];
      e.s = (k == 0);
      e.l = (k == width - 1) && !ap;
      p   = p ^ word[k];
      push_item(id, e);
    end
    if (ap) begin
      e.b = p;
      e.s = 1'b0;
      e.l = 1'b1;
      push_item(id, e);
    end
  endtask

  task automatic push_vec(input vec_t v);
    exp_t e;
    for (int k = 0; k < 8; k++) begin
      e.b = v.seq[k];
      e.s = (k == 0);
      e.l = 1'b0;
      push_item(0, e);
    end
    e.b = v.par;
    e.s = 1'b0;
    e.l = 1'b1;
    push_item(0, e);
  endtask

  task automatic mon(input int id, input logic v, input logic o, input logic s,
                     input logic l, input logic r, input logic wv);
    exp_t e;
    int   n;
    n = (id == 0) ? q0.size() : (id == 1) ? q1.size() : q2.size();
    if (rst) ones[id] = 1'b0;
    if (v) begin
      run[id]++;
      if (n == 0) begin
        chk($sformatf("extra_bit%0d", id), 32'd1, 32'd0);
      end else begin
        case (id)
          0:       e = q0.pop_front();
          1:       e = q1.pop_front();
          default: e = q2.pop_front();
        endcase
        chk($sformatf("seqOut%0d", id), o, e.b);
        chk($sformatf("frameStart%0d", id), s, e.s);
        chk($sformatf("frameLast%0d", id), l, e.l);
      end
      chk($sformatf("ready_in_frame%0d", id), r, l && (gap_cfg[id] == 0));
      ones[id] = ones[id] ^ o;
      if (s && seen_last[id]) gap_meas[id] = gapz[id];
      if (l) begin
        seen_last[id] = 1'b1;
        gapz[id] = 0;
        if (ap_cfg[id]) chk($sformatf("checker_even%0d", id), !ones[id], 1'b1);
      end
    end else begin
      if (run[id] > run_max[id]) run_max[id] = run[id];
      run[id] = 0;
      gapz[id]++;
      chk($sformatf("idle_outs%0d", id), {o, s, l}, 3'b000);
    end
    xf[id] = wv && r;
  endtask

  task automatic step();
    @(negedge clk);
    mon(0, a_if.seqValid, a_if.seqOut, a_if.frameStart, a_if.frameLast, a_if.wordReady, a_if.wordValid);
    mon(1, b_if.seqValid, b_if.seqOut, b_if.frameStart, b_if.frameLast, b_if.wordReady, b_if.wordValid);
    mon(2, c_if.seqValid, c_if.seqOut, c_if.frameStart, c_if.frameLast, c_if.wordReady, c_if.wordValid);
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int id, input logic vld, input logic [7:0] word);
    case (id)
      0: begin a_if.wordValid = vld; a_if.wordIn = word; end
      1: begin b_if.wordValid = vld; b_if.wordIn = word; end
      default: begin c_if.wordValid = vld; c_if.wordIn = word[0]; end
    endcase
  endtask

  task automatic send(input int id, input logic [7:0] word);
    int k;
    drive(id, 1'b1, word);
    k = 0;
    do begin
      step();
      k++;
    end while (!xf[id] && k < 40);
    chk($sformatf("accept%0d", id), xf[id], 1'b1);
  endtask

  initial begin
    vec_t vt[6];
    vec_t v3;
    rst = 1'b1;
    drive(0, 1'b0, 8'h00);
    drive(1, 1'b0, 8'h00);
    drive(2, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      run[i] = 0; run_max[i] = 0; gapz[i] = 0; gap_meas[i] = -1;
      seen_last[i] = 1'b0; ones[i] = 1'b0; xf[i] = 1'b0;
    end
    vt[0] = '{8'hA5, 8'b10100101, 1'b0};
    vt[1] = '{8'h07, 8'b11100000, 1'b1};
    vt[2] = '{8'h00, 8'b00000000, 1'b0};
    vt[3] = '{8'hFF, 8'b11111111, 1'b0};
    vt[4] = '{8'h80, 8'b00000001, 1'b1};
    vt[5] = '{8'h3C, 8'b00111100, 1'b0};
    v3    = '{8'h03, 8'b11000000, 1'b0};

    #2;
    chk("rst_outs_a", {a_if.seqOut, a_if.seqValid, a_if.frameStart, a_if.frameLast}, 4'b0000);
    chk("rst_outs_b", {b_if.seqOut, b_if.seqValid, b_if.frameStart, b_if.frameLast}, 4'b0000);
    chk("rst_outs_c", {c_if.seqOut, c_if.seqValid, c_if.frameStart, c_if.frameLast}, 4'b0000);
    chk("rst_ready_a", a_if.wordReady, 1'b0);
    chk("rst_ready_c", c_if.wordReady, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("idle_ready_a", a_if.wordReady, 1'b1);
    chk("idle_ready_b", b_if.wordReady, 1'b1);
    chk("idle_ready_c", c_if.wordReady, 1'b1);

    for (int i = 0; i < 6; i++) begin
      push_vec(vt[i]);
      send(0, vt[i].word);
      drive(0, 1'b0, 8'h00);
    end
    repeat (12) step();

    // Back-to-back frames with wordValid held high
    run_max[0] = 0;
    gap_meas[0] = -1;
    push_word(0, 8, 1'b1, 8'hFF);
    send(0, 8'hFF);
    push_word(0, 8, 1'b1, 8'h01);
    send(0, 8'h01);
    drive(0, 1'b0, 8'h00);
    repeat (12) step();
    chk("b2b_valid_run", run_max[0], 18);
    chk("b2b_gap", gap_meas[0], 0);

    // Two-cycle idle gap between frames
    push_word(1, 8, 1'b1, 8'h5A);
    send(1, 8'h5A);
    push_word(1, 8, 1'b1, 8'hC3);
    send(1, 8'hC3);
    drive(1, 1'b0, 8'h00);
    repeat (14) step();
    chk("gap2_len", gap_meas[1], 2);

    // Single-bit frames without parity
    run_max[2] = 0;
    push_word(2, 1, 1'b0, 8'h01);
    send(2, 8'h01);
    push_word(2, 1, 1'b0, 8'h00);
    send(2, 8'h00);
    push_word(2, 1, 1'b0, 8'h01);
    send(2, 8'h01);
    drive(2, 1'b0, 8'h00);
    repeat (4) step();
    chk("w1_valid_run", run_max[2], 3);

    // Asynchronous reset on the 4th bit of 0xFF
    push_word(0, 8, 1'b1, 8'hFF);
    send(0, 8'hFF);
    drive(0, 1'b0, 8'h00);
    repeat (3) step();
    chk("pre_rst_bit4", {a_if.seqValid, a_if.seqOut}, 2'b11);
    #2;
    rst = 1'b1;
    q0.delete();
    #1;
    chk("async_rst_outs", {a_if.seqOut, a_if.seqValid, a_if.frameStart, a_if.frameLast}, 4'b0000);
    chk("async_rst_ready", a_if.wordReady, 1'b0);
    step();
    rst = 1'b0;
    #1;
    chk("post_rst_ready", a_if.wordReady, 1'b1);
    repeat (2) step();
    push_vec(v3);
    send(0, 8'h03);
    drive(0, 1'b0, 8'h00);
    repeat (12) step();

    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    chk("q2_drained", q2.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule
